can_bus_responder: RTL and testbench
====================================

# can_bus_responder

SJA1000-compatible responder for the Intel-mode multiplexed address/data bus driven by the SoC CAN controller interface (`can_ad`, ALE, CS#, WR#, RD#, INT#). It latches addresses and decodes write and read strobes, all sampled in the `sys_clk` domain. It holds a PeliCAN-subset register file with TX and RX buffers and drives an open-drain-style INT#. It sits at the far end of the bus, either as an FPGA-side CAN controller front end or as a bus-functional peer for system simulation.

## Interface
- `RESET_MODE`, default 8'h01: reset value of the MOD register.
- `sys_clk` input 1: system clock. All bus inputs are asynchronous to it.
- `rst_n` input 1: reset, asynchronous, active-low.
- `can_ad_i` input 8: multiplexed address/data from the pad.
- `can_ad_o` output 8: read data toward the pad.
- `can_ad_oe` output 1: 1 = responder drives the pad.
- `can_cs_n`, `can_ale`, `can_wr_n`, `can_rd_n` input 1 each: bus strobes.
- `can_rst_n` input 1: bus-side soft reset, active-low.
- `can_mode` input 1: 1 = Intel mode. When 0, all bus cycles are ignored.
- `can_int_n` output 1: interrupt, active-low.
- `status_i` input 8: live value returned by SR.
- `evt_i` input 8: single-cycle interrupt event pulses, one per IR bit.
- `cmd_o` output 8: last byte written to CMR.
- `tx_req_o` output 1: 1-cycle pulse, written CMR bit0 = 1.
- `rx_release_o` output 1: 1-cycle pulse, written CMR bit2 = 1.
- `tx_addr_i` input 4 / `tx_data_o` output 8: local read port into the TX buffer.
- `rx_we_i` input 1 / `rx_addr_i` input 4 / `rx_data_i` input 8: local write port into the RX buffer.

## Operation
- Input sync: ALE, CS#, WR#, RD#, `can_rst_n` and `can_ad_i[7:0]` each pass through 2 flops. All decoding below uses the synchronized copies. Edge detection compares stage 2 with a third flop.
- Address phase: on ALE falling edge, `addr_q <= ad_sync`.
- Write cycle:
  - While CS#=0 and WR#=0, `wdata_q <= ad_sync` every cycle.
  - On WR# rising edge with CS#=0, commit `wdata_q` to `addr_q`.
- Read cycle:
  - While CS#=0, RD#=0 and WR#=1: `can_ad_oe` = 1 and `can_ad_o` = registered read mux of `addr_q`.
  - Otherwise `can_ad_oe` = 0. CS#, RD# and WR# all low is treated as idle: no drive, no commit.
- Register map, by `addr_q`:
  - 0 MOD: read/write. Resets to RESET_MODE.
  - 1 CMR: write-only, reads 8'hFF. A write updates `cmd_o` and generates the pulses.
  - 2 SR: read-only, returns `status_i`.
  - 3 IR: read-only and sticky. `IR[k]` is set when `evt_i[k]` & `IER[k]`. The whole register clears on the RD# rising edge with CS#=0 and `addr_q`=3.
  - 4 IER: read/write, reset 0. Writing IER never sets IR retroactively.
  - 16–28: a write goes to `txbuf[addr-16]`; a read returns `rxbuf[addr-16]`. Each buffer is 13 bytes.
  - All others: writes ignored, reads 8'h00.
- Simultaneous events:
  - An event set on the same cycle as an IR clear wins: the bit stays 1.
  - A local `rx_we_i` to the byte being read updates `rxbuf` that cycle. The pad shows the new value on the next cycle.
  - `rx_addr_i` > 12 is ignored. `tx_addr_i` > 12 returns 8'h00.
- `can_int_n` is registered `~|IR`.
- Resets:
  - Synchronized `can_rst_n`=0 resets every register and output to its reset value on the next cycle. It also aborts any cycle in progress: no commit and no IR clear for that cycle.
  - `rst_n` does the same asynchronously.
  - Buffers are cleared by both resets.
- `can_mode`=0: no address latch, no commit, `can_ad_oe`=0.

## Timing
- Reset values:
  - `can_ad_o` 0, `can_ad_oe` 0, `can_int_n` 1.
  - `cmd_o` 0, `tx_req_o` 0, `rx_release_o` 0, `tx_data_o` 0.
  - MOD = RESET_MODE, IER 0, IR 0.
- Read drive: `can_ad_oe` rises 3 cycles after the RD# pin falls (2 sync + 1 register) and falls 3 cycles after RD# rises.
- Write commit: the register is updated 3 cycles after the WR# pin rises. `tx_req_o` and `rx_release_o` pulse on that same cycle.
- IR: set 1 cycle after `evt_i`; `can_int_n` low 2 cycles after `evt_i`. The IR clear and `can_int_n` release happen 3 and 4 cycles after the RD# rise.
- `tx_data_o`: 1-cycle latency from `tx_addr_i`.
- Bus requirement: ALE high, WR# low and RD# low phases are each ≥ 4 `sys_clk` cycles. Data must be stable for the whole WR# low phase. Shorter phases are unsupported.

## Test plan
- Reset: with `rst_n`=0, outputs take their reset values. Read addr 0 returns 8'h01, addr 4 returns 8'h00, addr 1 returns 8'hFF.
- Write IER=8'h05, then read it back: 8'h05. Write addr 9, then read it: 8'h00.
- Write CMR=8'h05: `cmd_o`=8'h05, one `tx_req_o` pulse and one `rx_release_o` pulse, 3 cycles after the WR# rise.
- Write bytes 16..28 = 8'hA0..8'hAC, then sweep `tx_addr_i` 0..12: `tx_data_o` follows 8'hA0..8'hAC with 1-cycle lag. Load `rxbuf` locally with 8'h30..8'h3C: bus reads of 16..28 return those values.
- With IER=8'h01:
  - `evt_i`=8'h03 sets IR=8'h01 and drives `can_int_n` low.
  - A read of addr 3 returns 8'h01, then IR clears and `can_int_n` returns to 1.
  - `evt_i[0]` pulsed on the clear cycle: IR stays 8'h01.
- Pulse `can_rst_n` low mid-write to MOD with data 8'h00: no commit, MOD reads 8'h01. With `can_mode`=0, reads keep `can_ad_oe`=0 and writes have no effect.

Source files
------------

// File: rtl/can_bus_responder.sv
// can_bus_responder: SJA1000-style Intel-mode bus responder.
// Bus strobes and AD pins are double-flopped into sys_clk. Address is latched
// on ALE fall, writes commit on WR# rise, reads drive a registered mux while
// RD# is low. Holds MOD/CMR/SR/IR/IER plus 13-byte TX and RX buffers.
module can_bus_responder #(
  parameter logic [7:0] RESET_MODE = 8'h01
) (
  input  logic       sys_clk,
  input  logic       rst_n,
  input  logic [7:0] can_ad_i,
  output logic [7:0] can_ad_o,
  output logic       can_ad_oe,
  input  logic       can_cs_n,
  input  logic       can_ale,
  input  logic       can_wr_n,
  input  logic       can_rd_n,
  input  logic       can_rst_n,
  input  logic       can_mode,
  output logic       can_int_n,
  input  logic [7:0] status_i,
  input  logic [7:0] evt_i,
  output logic [7:0] cmd_o,
  output logic       tx_req_o,
  output logic       rx_release_o,
  input  logic [3:0] tx_addr_i,
  output logic [7:0] tx_data_o,
  input  logic       rx_we_i,
  input  logic [3:0] rx_addr_i,
  input  logic [7:0] rx_data_i
);

  localparam int BUF_N = 13;

  // synchronizer stages; control vector is {rst_n, ale, cs_n, wr_n, rd_n}
  logic [7:0] r_ad_s1, r_ad_s2;
  logic [4:0] r_ctl_s1, r_ctl_s2;
  logic [2:0] r_edge_s3;   // {ale, wr_n, rd_n} delayed once more for edges

  logic [7:0] r_addr, r_wdata, r_mod, r_ier, r_ir;
  logic       r_abort;
  logic [7:0] r_txbuf [BUF_N];
  logic [7:0] r_rxbuf [BUF_N];

  logic       w_srst, w_ale, w_cs_n, w_wr_n, w_rd_n;
  logic       w_ale_fall, w_wr_rise, w_rd_rise;
  logic       w_bus_ok, w_commit, w_ir_clr, w_rd_act, w_buf_hit;
  logic [7:0] w_rmux;

  // two-flop synchronizers plus the third edge-detect flop
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ad_s1   <= '0;
      r_ad_s2   <= '0;
      r_ctl_s1  <= 5'b10111;
      r_ctl_s2  <= 5'b10111;
      r_edge_s3 <= 3'b011;
    end else begin
      r_ad_s1   <= can_ad_i;
      r_ad_s2   <= r_ad_s1;
      r_ctl_s1  <= {can_rst_n, can_ale, can_cs_n, can_wr_n, can_rd_n};
      r_ctl_s2  <= r_ctl_s1;
      r_edge_s3 <= {r_ctl_s2[3], r_ctl_s2[1], r_ctl_s2[0]};
    end
  end

  assign w_srst     = ~r_ctl_s2[4];
  assign w_ale      = r_ctl_s2[3];
  assign w_cs_n     = r_ctl_s2[2];
  assign w_wr_n     = r_ctl_s2[1];
  assign w_rd_n     = r_ctl_s2[0];
  assign w_ale_fall = r_edge_s3[2] & ~w_ale;
  assign w_wr_rise  = ~r_edge_s3[1] & w_wr_n;
  assign w_rd_rise  = ~r_edge_s3[0] & w_rd_n;

  // an aborted cycle (soft reset seen mid-cycle) stays dead until CS# deasserts
  assign w_bus_ok  = can_mode & ~r_abort & ~w_cs_n;
  assign w_commit  = w_bus_ok & w_wr_rise & w_rd_n;
  assign w_ir_clr  = w_bus_ok & w_rd_rise & w_wr_n & (r_addr == 8'd3);
  assign w_rd_act  = w_bus_ok & ~w_rd_n & w_wr_n;
  assign w_buf_hit = (r_addr[7:4] == 4'h1) && (r_addr[3:0] <= 4'd12);

  // register read mux; buffer window 0x10..0x1C maps by the low nibble
  always_comb begin
    w_rmux = 8'h00;
    case (r_addr)
      8'd0:    w_rmux = r_mod;
      8'd1:    w_rmux = 8'hFF;
      8'd2:    w_rmux = status_i;
      8'd3:    w_rmux = r_ir;
      8'd4:    w_rmux = r_ier;
      default: if (w_buf_hit) w_rmux = r_rxbuf[r_addr[3:0]];
    endcase
  end

  // register file, bus decode, interrupt and output registers
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr       <= '0;
      r_wdata      <= '0;
      r_mod        <= RESET_MODE;
      r_ier        <= '0;
      r_ir         <= '0;
      r_abort      <= 1'b0;
      cmd_o        <= '0;
      tx_req_o     <= 1'b0;
      rx_release_o <= 1'b0;
      tx_data_o    <= '0;
      can_ad_o     <= '0;
      can_ad_oe    <= 1'b0;
      can_int_n    <= 1'b1;
      for (int i = 0; i < BUF_N; i++) begin
        r_txbuf[i] <= '0;
        r_rxbuf[i] <= '0;
      end
    end else if (w_srst) begin
      r_addr       <= '0;
      r_wdata      <= '0;
      r_mod        <= RESET_MODE;
      r_ier        <= '0;
      r_ir         <= '0;
      r_abort      <= 1'b1;
      cmd_o        <= '0;
      tx_req_o     <= 1'b0;
      rx_release_o <= 1'b0;
      tx_data_o    <= '0;
      can_ad_o     <= '0;
      can_ad_oe    <= 1'b0;
      can_int_n    <= 1'b1;
      for (int i = 0; i < BUF_N; i++) begin
        r_txbuf[i] <= '0;
        r_rxbuf[i] <= '0;
      end
    end else begin
      if (w_cs_n) r_abort <= 1'b0;
      if (can_mode && w_ale_fall) r_addr <= r_ad_s2;
      if (!w_cs_n && !w_wr_n && w_rd_n) r_wdata <= r_ad_s2;

      tx_req_o     <= 1'b0;
      rx_release_o <= 1'b0;
      if (w_commit) begin
        case (r_addr)
          8'd0: r_mod <= r_wdata;
          8'd1: begin
            cmd_o        <= r_wdata;
            tx_req_o     <= r_wdata[0];
            rx_release_o <= r_wdata[2];
          end
          8'd4: r_ier <= r_wdata;
          default: if (w_buf_hit) r_txbuf[r_addr[3:0]] <= r_wdata;
        endcase
      end

      if (rx_we_i && rx_addr_i <= 4'd12) r_rxbuf[rx_addr_i] <= rx_data_i;

      // a new event on the clear cycle survives the clear
      r_ir      <= (w_ir_clr ? 8'h00 : r_ir) | (evt_i & r_ier);
      can_int_n <= ~|r_ir;

      can_ad_oe <= w_rd_act;
      can_ad_o  <= w_rd_act ? w_rmux : 8'h00;
      tx_data_o <= (tx_addr_i <= 4'd12) ? r_txbuf[tx_addr_i] : 8'h00;
    end
  end

endmodule

// File: tb/tb_can_bus_responder.sv
// Directed + randomized bench for can_bus_responder with a register-level
// reference model (plain arrays, updated per bus transaction).
module tb_can_bus_responder;

  logic       sys_clk = 1'b0;
  logic       rst_n;
  logic [7:0] can_ad_i, can_ad_o;
  logic       can_ad_oe;
  logic       can_cs_n, can_ale, can_wr_n, can_rd_n, can_rst_n, can_mode;
  logic       can_int_n;
  logic [7:0] status_i, evt_i, cmd_o;
  logic       tx_req_o, rx_release_o;
  logic [3:0] tx_addr_i;
  logic [7:0] tx_data_o;
  logic       rx_we_i;
  logic [3:0] rx_addr_i;
  logic [7:0] rx_data_i;

  int checks = 0;
  int errors = 0;
  int txreq_cnt = 0;
  int rxrel_cnt = 0;

  // reference model state
  logic [7:0] m_mod, m_ier, m_ir, m_cmd;
  logic [7:0] m_tx [13];
  logic [7:0] m_rx [13];

  always #5 sys_clk = ~sys_clk;

  can_bus_responder #(.RESET_MODE(8'h01)) dut (
    .sys_clk(sys_clk), .rst_n(rst_n),
    .can_ad_i(can_ad_i), .can_ad_o(can_ad_o), .can_ad_oe(can_ad_oe),
    .can_cs_n(can_cs_n), .can_ale(can_ale), .can_wr_n(can_wr_n), .can_rd_n(can_rd_n),
    .can_rst_n(can_rst_n), .can_mode(can_mode), .can_int_n(can_int_n),
    .status_i(status_i), .evt_i(evt_i), .cmd_o(cmd_o),
    .tx_req_o(tx_req_o), .rx_release_o(rx_release_o),
    .tx_addr_i(tx_addr_i), .tx_data_o(tx_data_o),
    .rx_we_i(rx_we_i), .rx_addr_i(rx_addr_i), .rx_data_i(rx_data_i)
  );

  always @(negedge sys_clk) begin
    if (tx_req_o) txreq_cnt++;
    if (rx_release_o) rxrel_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic model_reset();
    m_mod = 8'h01; m_ier = 8'h00; m_ir = 8'h00; m_cmd = 8'h00;
    for (int i = 0; i < 13; i++) begin m_tx[i] = 8'h00; m_rx[i] = 8'h00; end
  endtask

  function automatic logic [7:0] model_read(input logic [7:0] a, input logic [7:0] st);
    if (a == 0) return m_mod;
    if (a == 1) return 8'hFF;
    if (a == 2) return st;
    if (a == 3) return m_ir;
    if (a == 4) return m_ier;
    if (a >= 16 && a <= 28) return m_rx[a - 16];
    return 8'h00;
  endfunction

  task automatic model_write(input logic [7:0] a, input logic [7:0] d);
    if (a == 0) m_mod = d;
    else if (a == 1) m_cmd = d;
    else if (a == 4) m_ier = d;
    else if (a >= 16 && a <= 28) m_tx[a - 16] = d;
  endtask

  task automatic addr_phase(input logic [7:0] a);
    can_ad_i = a; can_ale = 1'b1;
    step(4);
    can_ale = 1'b0;
    step(3);
  endtask

  // ends exactly at the WR# rise
  task automatic wr_start(input logic [7:0] a, input logic [7:0] d);
    addr_phase(a);
    can_ad_i = d; can_cs_n = 1'b0; can_wr_n = 1'b0;
    step(5);
    can_wr_n = 1'b1;
  endtask

  task automatic cyc_end();
    step(4);
    can_cs_n = 1'b1;
    step(2);
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
    wr_start(a, d);
    cyc_end();
    if (can_mode) model_write(a, d);
  endtask

  // samples pad mid-strobe, ends exactly at the RD# rise
  task automatic rd_start(input logic [7:0] a, output logic [7:0] d, output logic oe);
    addr_phase(a);
    can_cs_n = 1'b0; can_rd_n = 1'b0;
    step(5);
    d = can_ad_o; oe = can_ad_oe;
    can_rd_n = 1'b1;
  endtask

  task automatic bus_read_chk(input string tag, input logic [7:0] a);
    logic [7:0] d, e;
    logic oe;
    status_i = 8'($urandom);
    e = model_read(a, status_i);
    rd_start(a, d, oe);
    chk(tag, d, e);
    chk({tag, "_oe"}, oe, 1'b1);
    if (a == 3) m_ir = 8'h00;
    cyc_end();
  endtask

  initial begin
    logic [7:0] d, a;
    logic oe;
    int t0, r0;

    rst_n = 1'b0; can_ad_i = '0; can_cs_n = 1'b1; can_ale = 1'b0; can_wr_n = 1'b1;
    can_rd_n = 1'b1; can_rst_n = 1'b1; can_mode = 1'b1; status_i = '0; evt_i = '0;
    tx_addr_i = '0; rx_we_i = 1'b0; rx_addr_i = '0; rx_data_i = '0;
    model_reset();
    step(3);
    chk("rst_ad_o", can_ad_o, 8'h00);
    chk("rst_oe", can_ad_oe, 1'b0);
    chk("rst_int_n", can_int_n, 1'b1);
    chk("rst_cmd", cmd_o, 8'h00);
    chk("rst_pulses", {tx_req_o, rx_release_o}, 2'b00);
    chk("rst_txdata", tx_data_o, 8'h00);
    rst_n = 1'b1;
    step(2);

    bus_read_chk("rd_mod_rst", 8'd0);
    bus_read_chk("rd_ier_rst", 8'd4);
    bus_read_chk("rd_cmr", 8'd1);

    bus_write(8'd4, 8'h05);
    bus_read_chk("rd_ier", 8'd4);
    bus_write(8'd9, 8'h5A);
    bus_read_chk("rd_unmapped", 8'd9);

    // CMR pulses land 3 cycles after the WR# rise
    t0 = txreq_cnt; r0 = rxrel_cnt;
    wr_start(8'd1, 8'h05);
    step(2);
    chk("cmr_early", {tx_req_o, rx_release_o}, 2'b00);
    step(1);
    chk("cmr_pulse", {tx_req_o, rx_release_o}, 2'b11);
    chk("cmd_o", cmd_o, 8'h05);
    step(1);
    chk("cmr_after", {tx_req_o, rx_release_o}, 2'b00);
    cyc_end();
    model_write(8'd1, 8'h05);
    chk("txreq_count", txreq_cnt - t0, 1);
    chk("rxrel_count", rxrel_cnt - r0, 1);

    // read-drive latency: 3 cycles each way
    addr_phase(8'd0);
    can_cs_n = 1'b0; can_rd_n = 1'b0;
    step(2); chk("oe_rise_early", can_ad_oe, 1'b0);
    step(1); chk("oe_rise", can_ad_oe, 1'b1);
    chk("oe_data", can_ad_o, m_mod);
    can_rd_n = 1'b1;
    step(2); chk("oe_fall_early", can_ad_oe, 1'b1);
    step(1); chk("oe_fall", can_ad_oe, 1'b0);
    cyc_end();

    // TX buffer via bus, then swept through the local port
    for (int i = 0; i < 13; i++) bus_write(8'(16 + i), 8'(8'hA0 + i));
    for (int i = 0; i < 16; i++) begin
      tx_addr_i = 4'(i);
      step(1);
      chk($sformatf("tx_sweep%0d", i), tx_data_o, (i <= 12) ? m_tx[i] : 8'h00);
    end

    // RX buffer loaded locally (index 13..15 must be ignored), read over bus
    for (int i = 0; i < 16; i++) begin
      rx_we_i = 1'b1; rx_addr_i = 4'(i); rx_data_i = 8'(8'h30 + i);
      step(1);
      if (i <= 12) m_rx[i] = 8'(8'h30 + i);
    end
    rx_we_i = 1'b0;
    for (int i = 0; i < 13; i++) bus_read_chk($sformatf("rx_rd%0d", i), 8'(16 + i));

    // randomized register traffic against the model
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 5))
        0: a = 8'($urandom_range(0, 4));
        1: a = 8'($urandom_range(5, 31));
        default: a = 8'(16 + $urandom_range(0, 12));
      endcase
      if ($urandom_range(0, 1) == 0) bus_write(a, 8'($urandom));
      else bus_read_chk($sformatf("rand_rd_a%0d", a), a);
      if ($urandom_range(0, 2) == 0) begin
        rx_we_i = 1'b1; rx_addr_i = 4'($urandom); rx_data_i = 8'($urandom);
        step(1);
        if (rx_addr_i <= 4'd12) m_rx[rx_addr_i] = rx_data_i;
        rx_we_i = 1'b0;
      end
    end
    for (int i = 0; i < 13; i++) begin
      tx_addr_i = 4'(i);
      step(1);
      chk($sformatf("rand_tx%0d", i), tx_data_o, m_tx[i]);
    end

    // interrupts: masked set, read clears, event on clear cycle survives
    bus_write(8'd4, 8'h01);
    evt_i = 8'h03;
    step(1);
    evt_i = 8'h00;
    m_ir = m_ir | (8'h03 & m_ier);
    chk("int_n_lag", can_int_n, 1'b1);
    step(1);
    chk("int_n_low", can_int_n, 1'b0);
    rd_start(8'd3, d, oe);
    chk("ir_read", d, m_ir);
    m_ir = 8'h00;
    step(3); chk("int_n_hold", can_int_n, 1'b0);
    step(1); chk("int_n_release", can_int_n, 1'b1);
    can_cs_n = 1'b1;
    step(2);

    evt_i = 8'h01;
    step(1);
    evt_i = 8'h00;
    m_ir = m_ir | (8'h01 & m_ier);
    step(2);
    rd_start(8'd3, d, oe);
    chk("ir_read2", d, m_ir);
    step(2);
    evt_i = 8'h01;
    step(1);
    evt_i = 8'h00;
    step(2);
    chk("int_n_evt_on_clr", can_int_n, 1'b0);
    can_cs_n = 1'b1;
    step(2);
    bus_read_chk("ir_survives", 8'd3);
    chk("int_n_final", can_int_n, 1'b1);

    // soft reset mid-write to MOD aborts the commit
    bus_write(8'd0, 8'h7E);
    addr_phase(8'd0);
    can_ad_i = 8'h00; can_cs_n = 1'b0; can_wr_n = 1'b0;
    step(2);
    can_rst_n = 1'b0;
    step(2);
    can_rst_n = 1'b1;
    step(3);
    can_wr_n = 1'b1;
    cyc_end();
    model_reset();
    bus_read_chk("srst_mod", 8'd0);
    bus_read_chk("srst_ier", 8'd4);
    bus_read_chk("srst_rx", 8'd16);
    tx_addr_i = 4'd0;
    step(1);
    chk("srst_tx", tx_data_o, 8'h00);
    chk("srst_cmd", cmd_o, 8'h00);

    // can_mode=0: no drive and no commit
    can_mode = 1'b0;
    rd_start(8'd0, d, oe);
    chk("mode0_oe", oe, 1'b0);
    cyc_end();
    bus_write(8'd4, 8'h77);
    can_mode = 1'b1;
    bus_read_chk("mode0_ier", 8'd4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
